coord_stream_gen: RTL

COORD_STREAM_GEN -- requirements
Module: coord_stream_gen

---
 rtl/coord_gen_pkg.sv | 42 ++++
 rtl/coord_step_rom.sv | 35 +++
 rtl/coord_stream_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/coord_gen_pkg.sv
// Shared types, span constants and the elaboration-time zoom-to-step table
// function for coord_stream_gen.
package coord_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN
    } coord_state_t;

    localparam int SPAN_RE_UNITS = 3;
    localparam int SPAN_IM_UNITS = 2;
    localparam int ZOOM_ENTRIES  = 32;

    typedef struct packed {
        longint step_re;
        longint step_im;
        longint half_w;
        longint half_h;
    } step_entry_t;

    // Reinterpret the low wl bits of v as a signed wl-bit word.
    function automatic longint wrap_word(longint v, int wl);
        int sh;
        sh = 64 - wl;
        return (v <<< sh) >>> sh;
    endfunction

    function automatic step_entry_t zoom_entry(int wl, int frac, int zoom, int sw, int sh);
        step_entry_t e;
        longint w;
        longint h;
        w = wrap_word(longint'(SPAN_RE_UNITS) <<< frac, wl) >>> zoom;
        h = wrap_word(longint'(SPAN_IM_UNITS) <<< frac, wl) >>> zoom;
        e.step_re = wrap_word(w / longint'(sw), wl);
        e.step_im = wrap_word(h / longint'(sh), wl);
        e.half_w  = w >>> 1;
        e.half_h  = h >>> 1;
        return e;
    endfunction

endpackage

// File: rtl/coord_step_rom.sv
// Constant table: clamped zoom -> per-pixel steps and half spans, built at elaboration.
module coord_step_rom
    import coord_gen_pkg::*;
#(
    parameter int WORD_LENGTH   = 32,
    parameter int FRAC          = 28,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        [4:0]             zoom,
    output logic signed [WORD_LENGTH-1:0] step_re,
    output logic signed [WORD_LENGTH-1:0] step_im,
    output logic signed [WORD_LENGTH-1:0] half_w,
    output logic signed [WORD_LENGTH-1:0] half_h
);

    logic [ZOOM_ENTRIES-1:0][WORD_LENGTH-1:0] tab_step_re;
    logic [ZOOM_ENTRIES-1:0][WORD_LENGTH-1:0] tab_step_im;
    logic [ZOOM_ENTRIES-1:0][WORD_LENGTH-1:0] tab_half_w;
    logic [ZOOM_ENTRIES-1:0][WORD_LENGTH-1:0] tab_half_h;

    for (genvar z = 0; z < ZOOM_ENTRIES; z++) begin : g_tab
        localparam step_entry_t ENTRY = zoom_entry(WORD_LENGTH, FRAC, z, SCREEN_WIDTH, SCREEN_HEIGHT);
        assign tab_step_re[z] = WORD_LENGTH'(ENTRY.step_re);
        assign tab_step_im[z] = WORD_LENGTH'(ENTRY.step_im);
        assign tab_half_w[z]  = WORD_LENGTH'(ENTRY.half_w);
        assign tab_half_h[z]  = WORD_LENGTH'(ENTRY.half_h);
    end

    assign step_re = tab_step_re[zoom];
    assign step_im = tab_step_im[zoom];
    assign half_w  = tab_half_w[zoom];
    assign half_h  = tab_half_h[zoom];

endmodule

// File: rtl/coord_stream_gen.sv
// Streams per-pixel complex-plane coordinates, LANES pixels per beat, for one frame.
// Optional COORD_CONTINUOUS_EN: restart the next frame automatically after the last beat.
module coord_stream_gen
    import coord_gen_pkg::*;
#(
    parameter int WORD_LENGTH   = 32,
    parameter int FRAC          = 28,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int LANES         = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic        [4:0]                   zoom,
    input  logic signed [WORD_LENGTH-1:0]       real_center,
    input  logic signed [WORD_LENGTH-1:0]       imag_center,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic        [10:0]                  out_x,
    output logic        [10:0]                  out_y,
    output logic        [LANES-1:0][WORD_LENGTH-1:0] out_re,
    output logic        [LANES-1:0][WORD_LENGTH-1:0] out_im,
    output logic                                out_sof,
    output logic                                out_eol,
    output logic                                out_eof,
    output logic                                busy
);

`ifdef COORD_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    coord_state_t state, state_next;

    logic        [4:0]             zoom_q;
    logic signed [WORD_LENGTH-1:0] rc_q, ic_q, real_min_q, imag_max_q, im_q;
    logic        [LANES-1:0][WORD_LENGTH-1:0] re_q, lane_start;
    logic        [10:0]            x_q, y_q;
    logic signed [WORD_LENGTH-1:0] step_re, step_im, half_w, half_h;
    logic signed [WORD_LENGTH-1:0] row_origin, lanes_step;
    logic                          accept, last_x, last_y, frame_done, relatch;

    coord_step_rom #(
        .WORD_LENGTH  (WORD_LENGTH),
        .FRAC         (FRAC),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_step_rom (
        .zoom   (zoom_q),
        .step_re(step_re),
        .step_im(step_im),
        .half_w (half_w),
        .half_h (half_h)
    );

    assign accept     = out_valid && out_ready;
    assign last_x     = (x_q == 11'(SCREEN_WIDTH - LANES));
    assign last_y     = (y_q == 11'(SCREEN_HEIGHT - 1));
    assign frame_done = accept && last_x && last_y;
    assign relatch    = ((state == IDLE) && start) || (CONTINUOUS && frame_done);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = RUN;
            RUN:     if (frame_done) state_next = CONTINUOUS ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == RUN);
        busy      = (state != IDLE);
        out_sof   = out_valid && (x_q == '0) && (y_q == '0);
        out_eol   = out_valid && last_x;
        out_eof   = out_valid && last_x && last_y;
    end

    // Line starts reuse the SETUP-time origin, so each lane is real_min + k*step by adds only.
    always_comb begin
        lane_start = '0;
        lanes_step = '0;
        row_origin = (state == SETUP) ? rc_q - half_w : real_min_q;
        lane_start[0] = row_origin;
        for (int unsigned k = 1; k < LANES; k++)
            lane_start[k] = lane_start[k-1] + step_re;
        for (int unsigned k = 0; k < LANES; k++)
            lanes_step = lanes_step + step_re;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zoom_q     <= '0;
            rc_q       <= '0;
            ic_q       <= '0;
            real_min_q <= '0;
            imag_max_q <= '0;
            re_q       <= '0;
            im_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            if (relatch) begin
                zoom_q <= (int'(zoom) > FRAC) ? 5'(FRAC) : zoom;
                rc_q   <= real_center;
                ic_q   <= imag_center;
            end
            if (state == SETUP) begin
                real_min_q <= row_origin;
                imag_max_q <= ic_q + half_h;
                re_q       <= lane_start;
                im_q       <= ic_q + half_h;
                x_q        <= '0;
                y_q        <= '0;
            end else if (accept) begin
                if (last_x) begin
                    x_q  <= '0;
                    y_q  <= y_q + 11'd1;
                    re_q <= lane_start;
                    im_q <= im_q - step_im;
                end else begin
                    x_q <= x_q + 11'(LANES);
                    for (int unsigned k = 0; k < LANES; k++)
                        re_q[k] <= re_q[k] + lanes_step;
                end
            end
        end
    end

    assign out_x = x_q;
    assign out_y = y_q;
    assign out_re = re_q;
    always_comb begin
        out_im = '0;
        for (int unsigned k = 0; k < LANES; k++)
            out_im[k] = im_q;
    end

endmodule
